bg_frame_flash_draw: RTL and testbench
======================================

BG_FRAME_FLASH_DRAW -- requirements
Module: bg_frame_flash_draw

Interface
REQ-001 Parameter X_FRAME, default 543: last x coordinate of the playfield; the right border column(s) end here.
REQ-002 Parameter Y_FRAME, default 479: last y coordinate of the playfield; the bottom border row(s) end here.
REQ-003 Parameter BORDER_W, default 1: border thickness in pixels, legal range 1..16.
REQ-004 Parameter FLASH_COUNT, default 3: number of ON/OFF flash cycles per request, legal range 1..15.
REQ-005 Parameter FLASH_FRAMES, default 8: frames per flash phase, legal range 1..63.
REQ-006 clk  input  1  pixel clock.
REQ-007 resetN  input  1  reset, asynchronous, active-low.
REQ-008 startOfFrame  input  1  single-cycle pulse marking the first pixel of each frame.
REQ-009 pixelX  input  11  current pixel column.
REQ-010 pixelY  input  11  current pixel row.
REQ-011 flashReq  input  1  single-cycle request to flash the border (e.g. base hit).
REQ-012 BG_RGB  output  8  background colour, RRRGGGBB.
REQ-013 border  output  1  high when the current pixel is inside the border region.
REQ-014 flashBusy  output  1  high while a flash sequence is in progress.

Function
REQ-015 BG_RGB and border SHALL be registered, with 1-cycle latency from pixelX/pixelY.
REQ-016 Border region: pixelY<=Y_FRAME && (pixelX<BORDER_W || (pixelX>X_FRAME-BORDER_W && pixelX<=X_FRAME)), OR pixelX<=X_FRAME && (pixelY<BORDER_W || (pixelY>Y_FRAME-BORDER_W && pixelY<=Y_FRAME)).
REQ-017 Side panel: pixelX>X_FRAME SHALL output BG_RGB=8'h6D with border=0.
REQ-018 Playfield interior, and pixelY>Y_FRAME with pixelX<=X_FRAME: BG_RGB=8'h00, border=0.
REQ-019 Border pixels SHALL output 8'hFF, except in state FLASH_ON, where they SHALL output 8'hE0; border=1 in both cases, independent of flash state.
REQ-020 FSM states: IDLE, FLASH_ON, FLASH_OFF. flashBusy SHALL be registered and equal 1 whenever state!=IDLE.
REQ-021 IDLE→FLASH_ON on flashReq=1; on entry, the frame counter and the flash counter SHALL be cleared.
REQ-022 In FLASH_ON/FLASH_OFF, the frame counter SHALL increment on each startOfFrame; when startOfFrame arrives with frameCnt==FLASH_FRAMES-1, the counter SHALL clear and the phase SHALL end.
REQ-023 End of FLASH_ON → FLASH_OFF.
REQ-024 End of FLASH_OFF → IDLE if flashCnt==FLASH_COUNT-1; otherwise → FLASH_ON with flashCnt+1.
REQ-025 flashReq SHALL be ignored outside IDLE, including in the cycle of the transition to IDLE; no requests are queued.
REQ-026 A flashReq and a startOfFrame in the same cycle in IDLE: enter FLASH_ON; the startOfFrame is not counted.
REQ-027 The state change SHALL affect BG_RGB from the next registered pixel onward.
REQ-028 Counter widths SHALL be 6 bits (frames) and 4 bits (flashes); counters SHALL never wrap within a legal parameter range.

Reset
REQ-029 resetN=0 SHALL asynchronously force state=IDLE, all counters=0, BG_RGB=8'h00, border=0, flashBusy=0.
REQ-030 Reset asserted mid-flash SHALL abort the sequence; after release, the block idles until a new flashReq.

Verification
REQ-031 Defaults, no flash, pixel (0,100) → next cycle BG_RGB=FF, border=1; pixel (543,479) → FF, border=1; pixel (544,10) → 6D, border=0; pixel (300,200) → 00, border=0.
REQ-032 BORDER_W=4: pixel (3,200) → FF, border=1; pixel (4,200) → 00; pixel (540,200) → FF; pixel (539,200) → 00.
REQ-033 Defaults, flashReq once → flashBusy=1 next cycle; border pixels E0 for 8 startOfFrame pulses, then FF for 8, repeated 3 times; flashBusy falls after the 48th startOfFrame.
REQ-034 flashReq pulsed during FLASH_OFF of the second flash → no extension; total duration remains 48 frames.
REQ-035 Reset pulsed after 10 frames of flash → immediate flashBusy=0 and BG_RGB=00; after release, border pixels FF.
REQ-036 FLASH_COUNT=1, FLASH_FRAMES=1 → exactly one frame E0, one frame FF, then IDLE; flashReq in the cycle IDLE is re-entered → ignored.

Source files
------------

// File: rtl/bg_frame_flash_draw.sv
// Background/frame painter with a border flash sequencer.
// Latency: BG_RGB/border are registered, 1 cycle after pixelX/pixelY; flashBusy is registered.
// Backpressure: none; the pixel stream is consumed every cycle and extra flash requests are dropped.
//
// Ports:
//   clk          pixel clock
//   resetN       asynchronous active-low reset
//   startOfFrame single-cycle pulse on the first pixel of each frame
//   pixelX/Y     current pixel coordinates (11 bits each)
//   flashReq     single-cycle request to flash the border
//   BG_RGB       background colour, RRRGGGBB
//   border       current pixel is part of the playfield border
//   flashBusy    a flash sequence is running
module bg_frame_flash_draw #(
  parameter int X_FRAME      = 543,
  parameter int Y_FRAME      = 479,
  parameter int BORDER_W     = 1,
  parameter int FLASH_COUNT  = 3,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        flashReq,
  output logic [7:0]  BG_RGB,
  output logic        border,
  output logic        flashBusy
);

  localparam logic [10:0] X_LAST  = 11'(X_FRAME);
  localparam logic [10:0] Y_LAST  = 11'(Y_FRAME);
  // Pixels strictly beyond these are in the right/bottom border band.
  localparam logic [10:0] X_INNER = 11'(X_FRAME - BORDER_W);
  localparam logic [10:0] Y_INNER = 11'(Y_FRAME - BORDER_W);
  localparam logic [10:0] BW      = 11'(BORDER_W);

  localparam logic [5:0] FRAME_LAST = 6'(FLASH_FRAMES - 1);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_COUNT - 1);

  localparam logic [7:0] RGB_BLACK = 8'h00;
  localparam logic [7:0] RGB_WHITE = 8'hFF;
  localparam logic [7:0] RGB_RED   = 8'hE0;
  localparam logic [7:0] RGB_PANEL = 8'h6D;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } state_t;

  state_t      state_q;
  logic [5:0]  frame_cnt_q;
  logic [3:0]  flash_cnt_q;
  logic        busy_q;
  logic [7:0]  rgb_q;
  logic        border_q;

  logic [7:0]  rgb_d;
  logic        border_d;
  logic        in_col_band;
  logic        in_row_band;
  logic        in_border;
  logic        in_panel;
  logic        phase_end;

  // ---------------------------------------------------------------------
  // Pixel classification
  // ---------------------------------------------------------------------
  always_comb begin
    in_col_band = (pixelX < BW) || ((pixelX > X_INNER) && (pixelX <= X_LAST));
    in_row_band = (pixelY < BW) || ((pixelY > Y_INNER) && (pixelY <= Y_LAST));
    // A band only counts as border where it overlaps the playfield span
    // of the other axis.
    in_border   = ((pixelY <= Y_LAST) && in_col_band) ||
                  ((pixelX <= X_LAST) && in_row_band);
    in_panel    = (pixelX > X_LAST);
  end

  always_comb begin
    rgb_d    = RGB_BLACK;
    border_d = 1'b0;
    if (in_panel) begin
      rgb_d = RGB_PANEL;
    end else if (in_border) begin
      border_d = 1'b1;
      // Colour follows the current registered state, so a state change
      // shows up on the pixel registered after it.
      rgb_d    = (state_q == FLASH_ON) ? RGB_RED : RGB_WHITE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q    <= RGB_BLACK;
      border_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      border_q <= border_d;
    end
  end

  // ---------------------------------------------------------------------
  // Flash sequencer
  // ---------------------------------------------------------------------
  assign phase_end = startOfFrame && (frame_cnt_q == FRAME_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      flash_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A coincident startOfFrame is not counted: counters start at 0.
          if (flashReq) begin
            state_q     <= FLASH_ON;
            frame_cnt_q <= '0;
            flash_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        FLASH_ON: begin
          if (phase_end) begin
            frame_cnt_q <= '0;
            state_q     <= FLASH_OFF;
          end else if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_q + 6'd1;
          end
        end
        FLASH_OFF: begin
          if (phase_end) begin
            frame_cnt_q <= '0;
            if (flash_cnt_q == FLASH_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              flash_cnt_q <= flash_cnt_q + 4'd1;
              state_q     <= FLASH_ON;
            end
          end else if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_q + 6'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          frame_cnt_q <= '0;
          flash_cnt_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign BG_RGB    = rgb_q;
  assign border    = border_q;
  assign flashBusy = busy_q;

endmodule

// File: tb/tb_bg_frame_flash_draw.sv
module tb_bg_frame_flash_draw;

  localparam int XF = 543;
  localparam int YF = 479;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sof;
  logic        req;
  logic [10:0] px;
  logic [10:0] py;
  logic [7:0]  rgb  [3];
  logic        brd  [3];
  logic        busy [3];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a flash is "active" for a fixed number of counted
  // frames after acceptance; the phase is derived by division.
  bit active [3];
  int nsof   [3];

  always #5 clk = ~clk;

  bg_frame_flash_draw u0 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .flashReq(req), .BG_RGB(rgb[0]), .border(brd[0]), .flashBusy(busy[0]));

  bg_frame_flash_draw #(.BORDER_W(4)) u1 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .flashReq(req), .BG_RGB(rgb[1]), .border(brd[1]), .flashBusy(busy[1]));

  bg_frame_flash_draw #(.FLASH_COUNT(1), .FLASH_FRAMES(1)) u2 (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
    .flashReq(req), .BG_RGB(rgb[2]), .border(brd[2]), .flashBusy(busy[2]));

  function automatic int bw_of(int k);
    return (k == 1) ? 4 : 1;
  endfunction

  function automatic int fc_of(int k);
    return (k == 2) ? 1 : 3;
  endfunction

  function automatic int ff_of(int k);
    return (k == 2) ? 1 : 8;
  endfunction

  function automatic void ref_pix(input int k, input int x, input int y, input bit on,
                                  output logic [7:0] e_rgb, output logic e_brd);
    int  bw;
    bit  inb;
    bw  = bw_of(k);
    inb = ((y <= YF) && ((x < bw) || ((x > XF - bw) && (x <= XF)))) ||
          ((x <= XF) && ((y < bw) || ((y > YF - bw) && (y <= YF))));
    if (x > XF) begin
      e_rgb = 8'h6D; e_brd = 1'b0;
    end else if (inb) begin
      e_rgb = on ? 8'hE0 : 8'hFF; e_brd = 1'b1;
    end else begin
      e_rgb = 8'h00; e_brd = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[u%0d] t=%0t observed=%h expected=%h", tag, k, $time, obs, exp);
    end
  endtask

  // One pixel cycle: drive inputs, advance the model, check after the edge.
  task automatic tick(input bit s, input int x, input int y, input bit r);
    logic [7:0] er [3];
    logic       eb [3];
    logic       ey [3];
    sof = s; px = 11'(x); py = 11'(y); req = r;
    for (int k = 0; k < 3; k++) begin
      bit on;
      on = active[k] && (((nsof[k] / ff_of(k)) % 2) == 0);
      ref_pix(k, x, y, on, er[k], eb[k]);
      if (!active[k]) begin
        if (r) begin
          active[k] = 1'b1;
          nsof[k]   = 0;
        end
      end else if (s) begin
        nsof[k]++;
        if (nsof[k] == 2 * fc_of(k) * ff_of(k)) active[k] = 1'b0;
      end
      ey[k] = active[k];
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rgb", k, rgb[k], er[k]);
      chk("border", k, {7'd0, brd[k]}, {7'd0, eb[k]});
      chk("busy", k, {7'd0, busy[k]}, {7'd0, ey[k]});
    end
  endtask

  // Asynchronous reset pulse starting between clock edges.
  task automatic do_reset();
    resetN = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rgb", k, rgb[k], 8'h00);
      chk("rst_border", k, {7'd0, brd[k]}, 8'h00);
      chk("rst_busy", k, {7'd0, busy[k]}, 8'h00);
      active[k] = 1'b0;
      nsof[k]   = 0;
    end
    @(negedge clk);
    resetN = 1'b1;
  endtask

  function automatic int rnd_x();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(0, 6);
      1:       return $urandom_range(XF - 7, XF + 5);
      default: return $urandom_range(0, 2047);
    endcase
  endfunction

  function automatic int rnd_y();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(0, 6);
      1:       return $urandom_range(YF - 7, YF + 5);
      default: return $urandom_range(0, 2047);
    endcase
  endfunction

  // A short "frame": startOfFrame then a few random pixels.
  task automatic frame(input int req_odds);
    tick(1'b1, 0, 0, (req_odds > 0) && ($urandom_range(1, req_odds) == 1));
    for (int i = 0; i < 3; i++)
      tick(1'b0, rnd_x(), rnd_y(), (req_odds > 0) && ($urandom_range(1, req_odds) == 1));
  endtask

  initial begin
    resetN = 1'b0; sof = 1'b0; req = 1'b0; px = '0; py = '0;
    for (int k = 0; k < 3; k++) begin active[k] = 1'b0; nsof[k] = 0; end
    @(negedge clk);
    do_reset();

    // Directed pixel classification, defaults and BORDER_W=4.
    tick(1'b0, 0, 100, 1'b0);
    tick(1'b0, 543, 479, 1'b0);
    tick(1'b0, 544, 10, 1'b0);
    tick(1'b0, 300, 200, 1'b0);
    tick(1'b0, 3, 200, 1'b0);
    tick(1'b0, 4, 200, 1'b0);
    tick(1'b0, 540, 200, 1'b0);
    tick(1'b0, 539, 200, 1'b0);
    tick(1'b0, 100, 480, 1'b0);
    tick(1'b0, 544, 0, 1'b0);

    // Random pixels, idle.
    for (int i = 0; i < 150; i++) tick(1'b0, rnd_x(), rnd_y(), 1'b0);

    // Full default flash; request coincides with startOfFrame (not counted).
    tick(1'b1, 0, 50, 1'b1);
    for (int f = 0; f < 47; f++) frame(0);
    // Extra requests mid-sequence must not extend it.
    tick(1'b0, 0, 60, 1'b1);
    tick(1'b1, 0, 60, 1'b0);   // 48th counted frame: default flash ends
    tick(1'b0, 0, 60, 1'b0);

    // Random requests, including ones on the cycle a short flash ends.
    for (int f = 0; f < 60; f++) frame(5);

    // Reset after 10 frames of a fresh flash.
    do_reset();
    tick(1'b0, 0, 0, 1'b1);
    for (int f = 0; f < 10; f++) frame(0);
    do_reset();
    tick(1'b0, 0, 100, 1'b0);
    for (int f = 0; f < 12; f++) frame(0);

    // Back-to-back requests with startOfFrame every cycle.
    for (int i = 0; i < 80; i++)
      tick(1'b1, rnd_x(), rnd_y(), $urandom_range(0, 3) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
